fp_addsub_arbiter: RTL and testbench

//  Shares one pipelined FP32 add/sub datapath (unpack, mantissa swap/align, add, normalize) among
//  NUM_REQ requesters. Round-robin grants one operation per cycle, tags it, and tracks the fixed

---
 rtl/fp_addsub_arb_pkg.sv | 13 +
 rtl/fp_addsub_rsp_fifo.sv | 39 +++
 rtl/fp_addsub_arbiter.sv | 143 ++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_arb_pkg.sv
// fp_addsub_arb_pkg: operation encoding, response entry layout and id sizing helper
// shared by the FP32 add/sub arbiter and its response FIFO.
package fp_addsub_arb_pkg;
    typedef enum logic {OP_ADD, OP_SUB} fp_op_e;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int ID_W = id_width(4);
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } rsp_entry_t;
endpackage

// File: rtl/fp_addsub_rsp_fifo.sv
// fp_addsub_rsp_fifo: power-of-2 depth response FIFO with registered occupancy count;
// simultaneous push and pop leave the count unchanged.
module fp_addsub_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_pop;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin issue of FP32 add/sub ops onto one shared fixed-latency
// pipeline, in-order responses via a credit-guarded FIFO. Optional ADDSUB_ARB_PERF_EN perf counters.
module fp_addsub_arbiter
    import fp_addsub_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 32,
    parameter int LATENCY   = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_b,
    input  logic [NUM_REQ-1:0]            i_req_op,
    output logic                          o_dp_valid,
    output logic [SIZE_DATA-1:0]          o_dp_a,
    output logic [SIZE_DATA-1:0]          o_dp_b,
    output logic                          o_dp_op,
    input  logic                          i_dp_valid,
    input  logic [SIZE_DATA-1:0]          i_dp_result,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]  o_rsp_id,
    output logic [SIZE_DATA-1:0]          o_rsp_data,
`ifdef ADDSUB_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0]         o_perf_grant_cnt,
    output logic [15:0]                   o_perf_stall_cnt,
`endif
    output logic                          o_busy
);
    localparam int ID_W = id_width(NUM_REQ);
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    logic [ID_W-1:0]      r_ptr, w_win, w_idx, r_dp_id;
    logic                 w_found, w_credit, w_hs, w_op;
    logic [SIZE_DATA-1:0] w_a, w_b, r_dp_a, r_dp_b;
    logic                 r_dp_valid;
    fp_op_e               r_dp_op;
    logic [LATENCY-1:0]   r_tag_v;
    logic [ID_W-1:0]      r_tag_id [LATENCY];
    logic [CW-1:0]        r_used;
    logic                 w_tail_v, w_push, w_pop, w_lost, r_err;
    logic [$clog2(RSP_DEPTH):0] w_count;

    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        w_a     = '0;
        w_b     = '0;
        w_op    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == w_win) begin
                w_a  = i_req_a[k*SIZE_DATA +: SIZE_DATA];
                w_b  = i_req_b[k*SIZE_DATA +: SIZE_DATA];
                w_op = i_req_op[k];
            end
        end
    end

    // Credits cover everything issued but not yet popped, so the FIFO can never overflow.
    assign w_credit    = (r_used < CW'(RSP_DEPTH));
    assign w_hs        = w_found && w_credit;
    assign o_req_ready = w_hs ? NUM_REQ'(1) << w_win : '0;
    assign w_tail_v    = r_tag_v[LATENCY-1];
    assign w_push      = i_dp_valid && w_tail_v;
    assign w_lost      = w_tail_v && !i_dp_valid;
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_dp_valid  = r_dp_valid;
    assign o_dp_a      = r_dp_a;
    assign o_dp_b      = r_dp_b;
    assign o_dp_op     = r_dp_op;
    assign o_busy      = r_dp_valid || (|r_tag_v) || (w_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_dp_valid <= 1'b0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_dp_op    <= OP_ADD;
            r_dp_id    <= '0;
            r_tag_v    <= '0;
            for (int k = 0; k < LATENCY; k++) r_tag_id[k] <= '0;
            r_used     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_dp_valid <= w_hs;
            if (w_hs) begin
                r_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                r_dp_a  <= w_a;
                r_dp_b  <= w_b;
                r_dp_op <= fp_op_e'(w_op);
                r_dp_id <= w_win;
            end
            r_tag_v     <= LATENCY'({r_tag_v, r_dp_valid});
            r_tag_id[0] <= r_dp_id;
            for (int k = 1; k < LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
            r_used <= r_used + CW'(w_hs) - CW'(w_pop) - CW'(w_lost);
            r_err  <= r_err || (i_dp_valid != w_tail_v);
        end
    end

    fp_addsub_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(ID_W + SIZE_DATA)) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({r_tag_id[LATENCY-1], i_dp_result}),
        .i_pop   (w_pop),
        .o_valid (o_rsp_valid),
        .o_data  ({o_rsp_id, o_rsp_data}),
        .o_count (w_count)
    );

`ifdef ADDSUB_ARB_PERF_EN
    logic [15:0] r_gcnt [NUM_REQ];
    logic [15:0] r_stall;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) r_gcnt[k] <= '0;
            r_stall <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++)
                if (w_hs && w_win == ID_W'(k) && r_gcnt[k] != 16'hFFFF) r_gcnt[k] <= r_gcnt[k] + 1'b1;
            if ((|i_req_valid) && !w_credit && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
        end
    end
    always_comb begin
        o_perf_grant_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) o_perf_grant_cnt[k*16 +: 16] = r_gcnt[k];
    end
    assign o_perf_stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: random and directed stimulus against a queue-based reference
// of round-robin grants, credits and in-order responses; the datapath is a real-valued FP32 model.
module tb_fp_addsub_arbiter;
    localparam int N = 4, W = 32, L = 4, D = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0, req_op = '0, req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic           dp_valid, dp_op, dp_rvalid;
    logic [W-1:0]   dp_a, dp_b, dp_result;
    logic           rsp_valid, rsp_ready = 1'b0, busy;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
`ifdef ADDSUB_ARB_PERF_EN
    logic [N*16-1:0] perf_grant;
    logic [15:0]     perf_stall;
`endif
    int n_chk = 0, n_err = 0, n_hs = 0, cyc = 0, m_ptr = 0, m_used = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
        .o_dp_valid(dp_valid), .o_dp_a(dp_a), .o_dp_b(dp_b), .o_dp_op(dp_op),
        .i_dp_valid(dp_rvalid), .i_dp_result(dp_result),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
`ifdef ADDSUB_ARB_PERF_EN
        .o_perf_grant_cnt(perf_grant), .o_perf_stall_cnt(perf_stall),
`endif
        .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] x);
        if (x[30:0] == '0) return 0.0;
        return $bitstoreal({x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0});
    endfunction

    // Round-to-nearest-even from double; operands are kept close enough that the double sum is exact.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] q;
        int e;
        if (r == 0.0) return '0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        q = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) q = q + 25'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        return {d[63], e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic op);
        return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    // Shared datapath: LATENCY stages, deliberately not reset so stale beats survive a DUT reset.
    logic [L-1:0] pv = '0;
    logic [W-1:0] pd [L];
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], dp_valid};
        pd[0] <= fp_calc(dp_a, dp_b, dp_op);
        for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
    end
    assign dp_rvalid = pv[L-1];
    assign dp_result = pd[L-1];

    typedef struct { int id; logic [31:0] data; int t; } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        logic [N-1:0] er;
        logic ev;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_ptr  = 0;
            m_used = 0;
        end else begin
            er = '0;
            if (m_used < D)
                for (int k = 0; k < N; k++)
                    if (er == '0 && req_valid[(m_ptr + k) % N]) er[(m_ptr + k) % N] = 1'b1;
            chk("ready", req_ready, er);
            chk("busy", busy, m_used != 0);
            ev = (q.size() != 0) && (q[0].t <= cyc);
            chk("rsp_valid", rsp_valid, ev);
            if (ev && rsp_ready) begin
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                m_used--;
            end
            for (int k = 0; k < N; k++) if (req_valid[k] && req_ready[k]) n_hs++;
            for (int k = 0; k < N; k++)
                if (er[k]) begin
                    q.push_back('{k, fp_calc(req_a[k*W +: W], req_b[k*W +: W], req_op[k]), cyc + L + 2});
                    m_ptr = (k + 1) % N;
                    m_used++;
                end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_op[k]       = op;
    endtask

    task automatic await_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && (busy || q.size() != 0); i++) step(1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_empty"}, q.size(), 0);
    endtask

    initial begin
        int n, base;
        step(3);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dp_valid", dp_valid, 0);
        rst_n = 1'b1;
        step(1);

        rsp_ready = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, rnd_fp(), rnd_fp(), 1'($urandom));
        req_valid = '1;
        base = n_hs;
        step(40);
        chk("rr_grants", n_hs - base, 40);
`ifdef ADDSUB_ARB_PERF_EN
        for (int k = 0; k < N; k++) chk("perf_grant", perf_grant[k*16 +: 16], 10);
        chk("perf_stall_rr", perf_stall, 0);
`endif
        drain("rr");

        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        @(negedge clk);
        chk("single_dp_valid", dp_valid, 1);
        chk("single_dp_a", dp_a, 32'h3F800000);
        await_rsp(n);
        chk("single_latency", n, L + 1);
        chk("single_id", rsp_id, 0);
        chk("single_data", rsp_data, 32'h40400000);
        drain("single");

        set_req(2, 32'h40A00000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        await_rsp(n);
        chk("sub_seen", n > 0, 1);
        chk("sub_id", rsp_id, 2);
        chk("sub_data", rsp_data, 32'h40800000);
        drain("sub");

        rsp_ready = 1'b0;
        set_req(1, rnd_fp(), rnd_fp(), 1'b0);
        req_valid = 4'b0010;
        base = n_hs;
        step(20);
        chk("credit_accepts", n_hs - base, D);
        chk("credit_block", req_ready, 0);
`ifdef ADDSUB_ARB_PERF_EN
        chk("perf_stall", perf_stall, 12);
`endif
        rsp_ready = 1'b1;
        base = n_hs;
        step(10);
        chk("credit_resume", n_hs - base, 9);
        drain("credit");

        for (int k = 0; k < N; k++) set_req(k, rnd_fp(), rnd_fp(), 1'($urandom));
        req_valid = 4'b0111;
        step(3);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("midrst_ptr0", req_ready, 4'b0010);
        step(1);
        req_valid = '0;
        drain("midrst_a");
        set_req(3, 32'h40000000, 32'h40000000, 1'b0);
        req_valid = 4'b1000;
        step(1);
        req_valid = '0;
        await_rsp(n);
        chk("midrst_req3_id", rsp_id, 3);
        chk("midrst_req3_data", rsp_data, 32'h40800000);
        drain("midrst_b");

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) set_req(k, rnd_fp(), rnd_fp(), 1'($urandom));
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(3, 0) != 0);
            step(1);
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
